jtframe_ba0_arbiter: RTL and testbench

- Shares SDRAM bank 0 between up to four game-side requesters, e.g. main CPU, sub CPU, sound CPU and a RAM port.
- Sits between the game core and the frame's bank interface: it drives ba0_addr, ba_rd[0], ba_wr and ba0_din/ba0_din_m, and consumes ba_ack[0], ba_rdy[0] and sdram_dout.
- Grants round-robin, runs one transaction at a time, and returns read data plus a one-cycle completion strobe to the owning requester.

---
 rtl/jtframe_ba0_arbiter_if.sv | 49 ++++
 rtl/jtframe_ba0_arbiter.sv | 167 ++++++++++++++++
 tb/tb_jtframe_ba0_arbiter.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_ba0_arbiter_if.sv
// Bundles for the bank-0 arbiter: the game-side requester bus and the SDRAM bank-0 port.
// Game side: the core is master, the arbiter is slave. Bank side: the arbiter is master.

interface jtframe_ba0_req_if #(
    parameter int unsigned AW = 22,
    parameter int unsigned N  = 4
);
    logic              hold;
    logic [N-1:0]      req;
    logic [N-1:0]      we;
    logic [N*AW-1:0]   addr;
    logic [N*16-1:0]   din;
    logic [N*2-1:0]    din_m;
    logic [N-1:0]      ok;
    logic              err;
    logic [15:0]       dout;
    logic              busy;

    modport master (
        output hold, req, we, addr, din, din_m,
        input  ok, err, dout, busy
    );
    modport slave (
        input  hold, req, we, addr, din, din_m,
        output ok, err, dout, busy
    );
endinterface

interface jtframe_ba0_bank_if #(
    parameter int unsigned AW = 22
);
    logic [AW-1:0] ba0_addr;
    logic          ba0_rd;
    logic          ba0_wr;
    logic [15:0]   ba0_din;
    logic [1:0]    ba0_din_m;
    logic          ba0_ack;
    logic          ba0_rdy;
    logic [15:0]   sdram_dout;

    modport master (
        output ba0_addr, ba0_rd, ba0_wr, ba0_din, ba0_din_m,
        input  ba0_ack, ba0_rdy, sdram_dout
    );
    modport slave (
        input  ba0_addr, ba0_rd, ba0_wr, ba0_din, ba0_din_m,
        output ba0_ack, ba0_rdy, sdram_dout
    );
endinterface

// File: rtl/jtframe_ba0_arbiter.sv
// Round-robin arbiter sharing SDRAM bank 0 among up to four requesters, one transaction
// at a time, with an ack-to-rdy watchdog that aborts stuck transactions.

module jtframe_ba0_arbiter #(
    parameter int unsigned AW   = 22,
    parameter int unsigned N    = 4,
    parameter int unsigned TOUT = 255   // must be >= 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    jtframe_ba0_req_if.slave    game_io,
    jtframe_ba0_bank_if.master  bank_io
);
    localparam int unsigned SW = 2;
    localparam int unsigned TW = $clog2(TOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   last_q, last_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     din_q, din_d;
    logic [1:0]      din_m_q, din_m_d;
    logic            we_q, we_d;
    logic            err_l_q, err_l_d;
    logic [TW-1:0]   wdog_q, wdog_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [N-1:0]    ok_q, ok_d;
    logic            err_q, err_d;
    logic [15:0]     dout_q, dout_d;
    logic            busy_q, busy_d;

    logic            gnt_vld;
    logic [SW-1:0]   gnt_idx;
    logic [SW-1:0]   idx;

    // Scan downward in offset so the nearest set bit after last_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = int'(N); k >= 1; k--) begin
            idx = SW'((int'(last_q) + k) % int'(N));
            if (game_io.req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        slot_d  = slot_q;
        addr_d  = addr_q;
        din_d   = din_q;
        din_m_d = din_m_q;
        we_d    = we_q;
        err_l_d = err_l_q;
        wdog_d  = wdog_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ok_d    = '0;
        err_d   = 1'b0;
        dout_d  = dout_q;
        busy_d  = busy_q;
        case (state_q)
            StIdle: begin
                if (!game_io.hold && gnt_vld) begin
                    slot_d  = gnt_idx;
                    last_d  = gnt_idx;
                    addr_d  = game_io.addr[32'(gnt_idx) * AW +: AW];
                    din_d   = game_io.din[32'(gnt_idx) * 16 +: 16];
                    din_m_d = game_io.din_m[32'(gnt_idx) * 2 +: 2];
                    we_d    = game_io.we[gnt_idx];
                    rd_d    = ~game_io.we[gnt_idx];
                    wr_d    = game_io.we[gnt_idx];
                    err_l_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bank_io.ba0_ack) begin
                    rd_d   = 1'b0;
                    wr_d   = 1'b0;
                    // Counts cycles elapsed since the ack cycle.
                    wdog_d = TW'(1);
                    if (bank_io.ba0_rdy) begin
                        if (!we_q) dout_d = bank_io.sdram_dout;
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                wdog_d = wdog_q + TW'(1);
                if (bank_io.ba0_rdy) begin
                    if (!we_q) dout_d = bank_io.sdram_dout;
                    state_d = StDone;
                end else if (wdog_q >= TW'(TOUT - 1)) begin
                    // Abort so the strobe lands TOUT+1 cycles after the ack cycle.
                    err_l_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                ok_d[slot_q] = 1'b1;
                err_d        = err_l_q;
                err_l_d      = 1'b0;
                busy_d       = 1'b0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            last_q  <= SW'(N - 1);
            slot_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            din_m_q <= '0;
            we_q    <= 1'b0;
            err_l_q <= 1'b0;
            wdog_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ok_q    <= '0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            slot_q  <= slot_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            din_m_q <= din_m_d;
            we_q    <= we_d;
            err_l_q <= err_l_d;
            wdog_q  <= wdog_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
        end
    end

    assign game_io.ok         = ok_q;
    assign game_io.err        = err_q;
    assign game_io.dout       = dout_q;
    assign game_io.busy       = busy_q;
    assign bank_io.ba0_addr   = addr_q;
    assign bank_io.ba0_rd     = rd_q;
    assign bank_io.ba0_wr     = wr_q;
    assign bank_io.ba0_din    = din_q;
    assign bank_io.ba0_din_m  = din_m_q;

endmodule

// File: tb/tb_jtframe_ba0_arbiter.sv
// Bench for jtframe_ba0_arbiter: a scripted bank-0 controller serves grants while a
// scoreboard of expected transactions is checked at the bank request and at the ok strobe.

module tb_jtframe_ba0_arbiter;
    localparam int unsigned AW   = 22;
    localparam int unsigned N    = 4;
    localparam int unsigned TOUT = 255;

    typedef struct {
        int            slot;
        logic [AW-1:0] addr;
        logic          we;
        logic [15:0]   din;
        logic [1:0]    din_m;
        logic [15:0]   dout;
        logic          err;
    } exp_t;

    typedef struct {
        bit            seen_req;
        bit            held;
        bit            dropped;
        bit            got_ok;
        int            req_cyc;
        int            ack_cyc;
        int            rdy_cyc;
        int            ok_cyc;
        logic [AW-1:0] addr;
        logic          rd;
        logic          wr;
        logic [15:0]   din;
        logic [1:0]    din_m;
        logic          busy_mid;
        logic [N-1:0]  ok;
        logic          err;
        logic [15:0]   dout;
        logic          busy_ok;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc_n = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] m_dout = 16'h0;
    exp_t        sb[$];

    jtframe_ba0_req_if  #(.AW(AW), .N(N)) game ();
    jtframe_ba0_bank_if #(.AW(AW))        bank ();

    jtframe_ba0_arbiter #(.AW(AW), .N(N), .TOUT(TOUT)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .game_io (game),
        .bank_io (bank)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int s);
        logic [N-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    task automatic set_slot(input int s, input logic [AW-1:0] a, input logic w,
                            input logic [15:0] d, input logic [1:0] m);
        game.addr[s*AW +: AW] = a;
        game.din[s*16 +: 16]  = d;
        game.din_m[s*2 +: 2]  = m;
        game.we[s]            = w;
    endtask

    task automatic request(input int s, input logic [AW-1:0] a, input logic w,
                           input logic [15:0] d, input logic [1:0] m,
                           input logic [15:0] ed, input logic ee);
        exp_t e;
        set_slot(s, a, w, d, m);
        game.req[s] = 1'b1;
        e.slot  = s;
        e.addr  = a;
        e.we    = w;
        e.din   = d;
        e.din_m = m;
        e.dout  = ed;
        e.err   = ee;
        sb.push_back(e);
    endtask

    // Controller model: ack ack_dly cycles after the request appears, rdy rdy_dly cycles
    // after the ack (0 = same cycle, negative = never). Records what it observed.
    task automatic run_txn(input int ack_dly, input int rdy_dly, input logic [15:0] rdata,
                           input bit hold_at_ack, output obs_t o);
        o = '{default: '0};
        for (int i = 0; i < 30 && !(bank.ba0_rd || bank.ba0_wr); i++) cyc();
        if (!(bank.ba0_rd || bank.ba0_wr)) return;
        o.seen_req = 1'b1;
        o.req_cyc  = cyc_n;
        o.addr     = bank.ba0_addr;
        o.rd       = bank.ba0_rd;
        o.wr       = bank.ba0_wr;
        o.din      = bank.ba0_din;
        o.din_m    = bank.ba0_din_m;
        o.busy_mid = game.busy;
        o.held     = 1'b1;
        repeat (ack_dly) begin
            cyc();
            if ({bank.ba0_rd, bank.ba0_wr} !== {o.rd, o.wr} || bank.ba0_addr !== o.addr)
                o.held = 1'b0;
        end
        bank.ba0_ack = 1'b1;
        if (hold_at_ack) game.hold = 1'b1;
        o.ack_cyc = cyc_n;
        if (rdy_dly == 0) begin
            bank.ba0_rdy    = 1'b1;
            bank.sdram_dout = rdata;
            o.rdy_cyc       = cyc_n;
        end
        cyc();
        bank.ba0_ack    = 1'b0;
        bank.ba0_rdy    = 1'b0;
        bank.sdram_dout = ~rdata;
        o.dropped = !(bank.ba0_rd || bank.ba0_wr);
        if (rdy_dly > 0) begin
            repeat (rdy_dly - 1) cyc();
            bank.ba0_rdy    = 1'b1;
            bank.sdram_dout = rdata;
            o.rdy_cyc       = cyc_n;
            cyc();
            bank.ba0_rdy    = 1'b0;
            bank.sdram_dout = ~rdata;
        end
        for (int i = 0; i < int'(TOUT) + 30 && game.ok == '0; i++) cyc();
        if (game.ok == '0) return;
        o.got_ok  = 1'b1;
        o.ok      = game.ok;
        o.err     = game.err;
        o.dout    = game.dout;
        o.busy_ok = game.busy;
        o.ok_cyc  = cyc_n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        n_vec++;
        if ({game.ok, game.err, game.busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctl: got ok/err/busy %b want 0", {game.ok, game.err, game.busy});
        end
        n_vec++;
        if (game.dout !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_dout: got %h want 0000", game.dout);
        end
        n_vec++;
        if ({bank.ba0_addr, bank.ba0_rd, bank.ba0_wr, bank.ba0_din, bank.ba0_din_m} !== '0) begin
            n_bad++;
            $display("FAIL reset_bank: got addr %h rd %b wr %b din %h m %b want all 0",
                     bank.ba0_addr, bank.ba0_rd, bank.ba0_wr, bank.ba0_din, bank.ba0_din_m);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_read();
        obs_t o;
        exp_t e;
        int   r;
        request(0, 22'h000123, 1'b0, 16'h0, 2'b00, 16'hBEEF, 1'b0);
        r = cyc_n;
        run_txn(1, 4, 16'hBEEF, 1'b0, o);
        game.req[0] = 1'b0;
        e = sb.pop_front();
        m_dout = 16'hBEEF;
        n_vec++;
        if (!o.seen_req || o.req_cyc != r + 1) begin
            n_bad++;
            $display("FAIL rd_grant_latency: got seen %0d cyc %0d want cyc %0d", o.seen_req,
                     o.req_cyc, r + 1);
        end
        n_vec++;
        if ({o.addr, o.rd, o.wr} !== {e.addr, ~e.we, e.we}) begin
            n_bad++;
            $display("FAIL rd_bank_req: got addr %h rd %b wr %b want %h 1 0", o.addr, o.rd, o.wr,
                     e.addr);
        end
        n_vec++;
        if (!o.held || !o.dropped || o.busy_mid !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_handshake: got held %0d dropped %0d busy %b want 1 1 1", o.held,
                     o.dropped, o.busy_mid);
        end
        n_vec++;
        if (!o.got_ok || {o.ok, o.err, o.dout} !== {onehot(e.slot), e.err, e.dout}) begin
            n_bad++;
            $display("FAIL rd_result: got ok %b err %b dout %h want %b %b %h", o.ok, o.err,
                     o.dout, onehot(e.slot), e.err, e.dout);
        end
        n_vec++;
        if (o.ok_cyc - o.rdy_cyc != 2 || o.busy_ok !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_ok_timing: got rdy->ok %0d busy %b want 2 0",
                     o.ok_cyc - o.rdy_cyc, o.busy_ok);
        end
        cyc();
        n_vec++;
        if (game.ok !== '0 || bank.ba0_addr !== e.addr) begin
            n_bad++;
            $display("FAIL rd_ok_pulse: got ok %b addr %h want 0000 %h", game.ok, bank.ba0_addr,
                     e.addr);
        end
    endtask

    task automatic test_ack_rdy_same();
        obs_t o;
        exp_t e;
        request(1, 22'h0ABCDE, 1'b0, 16'h0, 2'b00, 16'h1234, 1'b0);
        run_txn(0, 0, 16'h1234, 1'b0, o);
        game.req[1] = 1'b0;
        e = sb.pop_front();
        m_dout = 16'h1234;
        n_vec++;
        if (!o.got_ok || {o.ok, o.err, o.dout} !== {onehot(e.slot), e.err, e.dout}
            || o.ok_cyc - o.ack_cyc != 2) begin
            n_bad++;
            $display("FAIL ackrdy_same: got ok %b err %b dout %h lat %0d want %b %b %h 2", o.ok,
                     o.err, o.dout, o.ok_cyc - o.ack_cyc, onehot(e.slot), e.err, e.dout);
        end
        cyc();
    endtask

    task automatic test_round_robin();
        obs_t o;
        exp_t e;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_dout = 16'h0;
        for (int s = 0; s < 4; s++)
            request(s, AW'(22'h100000 + s * 16), 1'b0, 16'h0, 2'b00, 16'(16'h1000 + s), 1'b0);
        for (int s = 0; s < 2; s++) begin
            e.slot = s; e.addr = AW'(22'h100000 + s * 16); e.we = 1'b0; e.din = 16'h0;
            e.din_m = 2'b00; e.dout = 16'(16'h1004 + s); e.err = 1'b0;
            sb.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            run_txn(0, 2, 16'(16'h1000 + i), 1'b0, o);
            if (i == 5) game.req = '0;
            e = sb.pop_front();
            n_vec++;
            if ({o.addr, o.rd, o.wr} !== {e.addr, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL rr_req%0d: got addr %h rd %b wr %b want %h 1 0", i, o.addr, o.rd,
                         o.wr, e.addr);
            end
            n_vec++;
            if (!o.got_ok || {o.ok, o.err, o.dout} !== {onehot(e.slot), e.err, e.dout}
                || o.ok_cyc - o.rdy_cyc != 2) begin
                n_bad++;
                $display("FAIL rr_ok%0d: got ok %b err %b dout %h lat %0d want %b %b %h 2", i,
                         o.ok, o.err, o.dout, o.ok_cyc - o.rdy_cyc, onehot(e.slot), e.err,
                         e.dout);
            end
        end
        m_dout = 16'h1005;
        cyc();
    endtask

    task automatic test_write();
        obs_t o;
        exp_t e;
        request(2, 22'h02AAAA, 1'b1, 16'h55AA, 2'b01, m_dout, 1'b0);
        run_txn(1, 3, 16'hFFFF, 1'b0, o);
        game.req[2] = 1'b0;
        game.we[2]  = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if ({o.addr, o.rd, o.wr, o.din, o.din_m} !== {e.addr, 1'b0, 1'b1, e.din, e.din_m}) begin
            n_bad++;
            $display("FAIL wr_bank_req: got addr %h rd %b wr %b din %h m %b want %h 0 1 %h %b",
                     o.addr, o.rd, o.wr, o.din, o.din_m, e.addr, e.din, e.din_m);
        end
        n_vec++;
        if (!o.got_ok || {o.ok, o.err, o.dout} !== {onehot(e.slot), e.err, e.dout}) begin
            n_bad++;
            $display("FAIL wr_result: got ok %b err %b dout %h want %b %b %h", o.ok, o.err,
                     o.dout, onehot(e.slot), e.err, e.dout);
        end
        cyc();
    endtask

    task automatic test_hold();
        obs_t o;
        exp_t e;
        int   cnt;
        int   h;
        game.hold = 1'b1;
        request(1, 22'h00BEE0, 1'b0, 16'h0, 2'b00, 16'hCAFE, 1'b0);
        cnt = 0;
        repeat (50) begin
            cyc();
            if (bank.ba0_rd || bank.ba0_wr || game.busy) cnt++;
        end
        n_vec++;
        if (cnt != 0) begin
            n_bad++;
            $display("FAIL hold_block: got %0d active cycles want 0", cnt);
        end
        game.hold = 1'b0;
        h = cyc_n;
        run_txn(0, 3, 16'hCAFE, 1'b1, o);
        game.req[1] = 1'b0;
        e = sb.pop_front();
        m_dout = 16'hCAFE;
        n_vec++;
        if (!o.seen_req || o.req_cyc != h + 1) begin
            n_bad++;
            $display("FAIL hold_release: got seen %0d cyc %0d want cyc %0d", o.seen_req,
                     o.req_cyc, h + 1);
        end
        n_vec++;
        if (!o.got_ok || {o.ok, o.err, o.dout} !== {onehot(e.slot), e.err, e.dout}) begin
            n_bad++;
            $display("FAIL hold_inflight: got ok %b err %b dout %h want %b %b %h", o.ok, o.err,
                     o.dout, onehot(e.slot), e.err, e.dout);
        end
        request(3, 22'h3F0F0F, 1'b0, 16'h0, 2'b00, 16'hD00D, 1'b0);
        cnt = 0;
        repeat (10) begin
            cyc();
            if (bank.ba0_rd || bank.ba0_wr) cnt++;
        end
        n_vec++;
        if (cnt != 0) begin
            n_bad++;
            $display("FAIL hold_after: got %0d request cycles want 0", cnt);
        end
        game.hold = 1'b0;
        run_txn(0, 1, 16'hD00D, 1'b0, o);
        game.req[3] = 1'b0;
        e = sb.pop_front();
        m_dout = 16'hD00D;
        n_vec++;
        if (!o.got_ok || {o.addr, o.ok, o.dout} !== {e.addr, onehot(e.slot), e.dout}) begin
            n_bad++;
            $display("FAIL hold_next: got addr %h ok %b dout %h want %h %b %h", o.addr, o.ok,
                     o.dout, e.addr, onehot(e.slot), e.dout);
        end
        cyc();
    endtask

    task automatic test_watchdog();
        obs_t o;
        exp_t e;
        request(0, 22'h012345, 1'b0, 16'h0, 2'b00, m_dout, 1'b1);
        run_txn(0, -1, 16'h0, 1'b0, o);
        game.req[0] = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (!o.got_ok || {o.ok, o.err, o.dout} !== {onehot(e.slot), e.err, e.dout}) begin
            n_bad++;
            $display("FAIL wdog_result: got ok %b err %b dout %h want %b %b %h", o.ok, o.err,
                     o.dout, onehot(e.slot), e.err, e.dout);
        end
        n_vec++;
        if (o.ok_cyc - o.ack_cyc != int'(TOUT) + 1) begin
            n_bad++;
            $display("FAIL wdog_latency: got %0d want %0d", o.ok_cyc - o.ack_cyc, TOUT + 1);
        end
        cyc();
        n_vec++;
        if ({game.ok, game.err} !== '0) begin
            n_bad++;
            $display("FAIL wdog_pulse: got ok %b err %b want 0 0", game.ok, game.err);
        end
        request(1, 22'h000042, 1'b0, 16'h0, 2'b00, 16'h4242, 1'b0);
        run_txn(0, 1, 16'h4242, 1'b0, o);
        game.req[1] = 1'b0;
        e = sb.pop_front();
        m_dout = 16'h4242;
        n_vec++;
        if (!o.got_ok || {o.ok, o.err, o.dout} !== {onehot(e.slot), e.err, e.dout}) begin
            n_bad++;
            $display("FAIL wdog_recover: got ok %b err %b dout %h want %b %b %h", o.ok, o.err,
                     o.dout, onehot(e.slot), e.err, e.dout);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        int   cnt;
        int   r;
        set_slot(2, 22'h03C3C3, 1'b0, 16'h1111, 2'b11);
        game.req[2] = 1'b1;
        cnt = 0;
        while (!bank.ba0_rd && cnt < 10) begin
            cyc();
            cnt++;
        end
        n_vec++;
        if (bank.ba0_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_req: got rd %b want 1", bank.ba0_rd);
        end
        bank.ba0_ack = 1'b1;
        cyc();
        bank.ba0_ack = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        game.req = '0;
        cyc();
        rst = 1'b0;
        n_vec++;
        if ({game.ok, game.err, game.busy, game.dout} !== '0
            || {bank.ba0_addr, bank.ba0_rd, bank.ba0_wr, bank.ba0_din, bank.ba0_din_m} !== '0)
        begin
            n_bad++;
            $display("FAIL rstmid_zero: got ok %b err %b busy %b dout %h addr %h din %h want 0",
                     game.ok, game.err, game.busy, game.dout, bank.ba0_addr, bank.ba0_din);
        end
        bank.ba0_rdy    = 1'b1;
        bank.sdram_dout = 16'hDEAD;
        cyc();
        bank.ba0_rdy = 1'b0;
        cnt = 0;
        repeat (5) begin
            if (game.ok != '0 || game.busy || game.dout != 16'h0) cnt++;
            cyc();
        end
        n_vec++;
        if (cnt != 0) begin
            n_bad++;
            $display("FAIL rstmid_stray_rdy: got %0d disturbed cycles want 0", cnt);
        end
        request(3, 22'h155555, 1'b0, 16'h0, 2'b00, 16'h7777, 1'b0);
        r = cyc_n;
        run_txn(0, 2, 16'h7777, 1'b0, o);
        game.req[3] = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (!o.seen_req || o.req_cyc != r + 1 || {o.addr, o.rd, o.wr} !== {e.addr, 1'b1, 1'b0})
        begin
            n_bad++;
            $display("FAIL rstmid_next_req: got cyc %0d addr %h rd %b want cyc %0d addr %h rd 1",
                     o.req_cyc, o.addr, o.rd, r + 1, e.addr);
        end
        n_vec++;
        if (!o.got_ok || {o.ok, o.err, o.dout} !== {onehot(e.slot), e.err, e.dout}) begin
            n_bad++;
            $display("FAIL rstmid_next_ok: got ok %b err %b dout %h want %b %b %h", o.ok, o.err,
                     o.dout, onehot(e.slot), e.err, e.dout);
        end
        cyc();
    endtask

    initial begin
        game.hold       = 1'b0;
        game.req        = '0;
        game.we         = '0;
        game.addr       = '0;
        game.din        = '0;
        game.din_m      = '0;
        bank.ba0_ack    = 1'b0;
        bank.ba0_rdy    = 1'b0;
        bank.sdram_dout = 16'h0;
        test_reset();
        test_single_read();
        test_ack_rdy_same();
        test_round_robin();
        test_write();
        test_hold();
        test_watchdog();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
